// File: rtl/mem_load_extend_if.sv
// Request/result handshake bundle for mem_load_extend.
// The slave side is the load-extend unit; the master side issues loads and consumes results.
interface mem_load_extend_if #(
  parameter int WORD_W = 32
);
  localparam int OFF_W = $clog2(WORD_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        load_type;
  logic [OFF_W-1:0]  byte_offset;
  logic [WORD_W-1:0] mem_word;
  logic [WORD_W-1:0] reg_old;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, load_type, byte_offset, mem_word, reg_old, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, load_type, byte_offset, mem_word, reg_old, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/mem_load_extend.sv
// Load-data extension/merge unit (LB/LBU/LH/LHU/LW/LWL/LWR) feeding a small in-order
// result FIFO, with a saturating count of misaligned/reserved requests.
module mem_load_extend #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_load_extend_if.slave      bus,
  input  logic                  err_clear,
  output logic [7:0]            err_count
);
  localparam int OFF_W = $clog2(WORD_W / 8);
  localparam int N     = WORD_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [WORD_W-1:0] ONES = '1;

  logic [7:0]        lane [N];
  logic [OFF_W-1:0]  half_off;
  logic [OFF_W-1:0]  lwl_off;
  logic [OFF_W+2:0]  lwl_sh;
  logic [OFF_W+2:0]  lwr_sh;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [WORD_W-1:0] res_data;
  logic              res_err;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = bus.mem_word[8*gi +: 8];
    end
  endgenerate

  // Halfword lane pair is taken from the even-aligned offset; odd offsets are flagged anyway.
  assign half_off = {bus.byte_offset[OFF_W-1:1], 1'b0};
  assign lwl_off  = OFF_W'(N - 1) - bus.byte_offset;
  assign lwl_sh   = {lwl_off, 3'b000};
  assign lwr_sh   = {bus.byte_offset, 3'b000};
  assign sel_byte = lane[bus.byte_offset];
  assign sel_half = {lane[half_off + 1'b1], lane[half_off]};

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (bus.load_type)
      3'd0: res_data = {{(WORD_W-8){sel_byte[7]}}, sel_byte};
      3'd1: res_data = {{(WORD_W-8){1'b0}}, sel_byte};
      3'd2: begin
        if (bus.byte_offset[0]) res_err = 1'b1;
        else res_data = {{(WORD_W-16){sel_half[15]}}, sel_half};
      end
      3'd3: begin
        if (bus.byte_offset[0]) res_err = 1'b1;
        else res_data = {{(WORD_W-16){1'b0}}, sel_half};
      end
      3'd4: begin
        if (bus.byte_offset != '0) res_err = 1'b1;
        else res_data = bus.mem_word;
      end
      // LWL fills the upper lanes from memory, LWR the lower ones; the rest keep reg_old.
      3'd5: res_data = (bus.mem_word << lwl_sh) | (bus.reg_old & ~(ONES << lwl_sh));
      3'd6: res_data = (bus.mem_word >> lwr_sh) | (bus.reg_old & ~(ONES >> lwr_sh));
      default: res_err = 1'b1;
    endcase
  end

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  logic [PTR_W:0]  wr_ptr_reg;
  logic [PTR_W:0]  rd_ptr_reg;
  logic [WORD_W:0] entry_mem [FIFO_DEPTH];
  logic [7:0]      err_count_reg;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign push       = bus.in_valid && !fifo_full;
  assign pop        = !fifo_empty && bus.out_ready;

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = entry_mem[rd_ptr_reg[PTR_W-1:0]][WORD_W-1:0];
  assign bus.out_err   = entry_mem[rd_ptr_reg[PTR_W-1:0]][WORD_W];
  assign err_count     = err_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) entry_mem[i] <= '0;
    end else begin
      if (push) begin
        entry_mem[wr_ptr_reg[PTR_W-1:0]] <= {res_err, res_data};
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_reg <= '0;
    end else if (err_clear) begin
      err_count_reg <= '0;
    end else if (push && res_err && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_load_extend.sv
// Directed bench for mem_load_extend: extension cases, errors, backpressure,
// error-count saturation/clear and mid-operation reset.
module tb_mem_load_extend;
  logic       clk;
  logic       reset;
  logic       err_clear;
  logic [7:0] err_count;
  int         n_cmp;
  int         n_err;

  mem_load_extend_if #(.WORD_W(32)) bus ();

  mem_load_extend #(.WORD_W(32), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_clear (err_clear),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] lt, input logic [1:0] off,
                      input logic [31:0] mem, input logic [31:0] rold);
    bus.load_type   = lt;
    bus.byte_offset = off;
    bus.mem_word    = mem;
    bus.reg_old     = rold;
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid    = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    err_clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.load_type = 3'd0;
    bus.byte_offset = 2'd0;
    bus.mem_word = '0;
    bus.reg_old = '0;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_err_count", 32'(err_count),     32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    reset = 1'b1;
    step();

    send(3'd0, 2'd2, 32'h12A45678, 32'h0);
    $display("LB  off2 -> %h err %0d", bus.out_data, bus.out_err);
    chk("lb_valid", 32'(bus.out_valid), 32'd1);
    chk("lb_data",  bus.out_data, 32'hFFFFFFA4);
    chk("lb_err",   32'(bus.out_err), 32'd0);
    pop_one();
    chk("lb_drained", 32'(bus.out_valid), 32'd0);

    send(3'd1, 2'd2, 32'h12A45678, 32'h0);
    $display("LBU off2 -> %h", bus.out_data);
    chk("lbu_data", bus.out_data, 32'h000000A4);
    pop_one();

    send(3'd2, 2'd1, 32'h12345678, 32'h0);
    $display("LH  off1 -> %h err %0d cnt %0d", bus.out_data, bus.out_err, err_count);
    chk("lh_mis_data", bus.out_data, 32'h0);
    chk("lh_mis_err",  32'(bus.out_err), 32'd1);
    chk("lh_mis_cnt",  32'(err_count), 32'd1);
    pop_one();

    send(3'd3, 2'd2, 32'h80010000, 32'h0);
    $display("LHU off2 -> %h", bus.out_data);
    chk("lhu_data", bus.out_data, 32'h00008001);
    chk("lhu_err",  32'(bus.out_err), 32'd0);
    pop_one();

    send(3'd2, 2'd2, 32'h80010000, 32'h0);
    $display("LH  off2 -> %h", bus.out_data);
    chk("lh_data", bus.out_data, 32'hFFFF8001);
    pop_one();

    send(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344);
    $display("LWL off1 -> %h", bus.out_data);
    chk("lwl_data", bus.out_data, 32'hCCDD3344);
    pop_one();

    send(3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344);
    $display("LWR off1 -> %h", bus.out_data);
    chk("lwr_data", bus.out_data, 32'h11AABBCC);
    pop_one();

    send(3'd5, 2'd3, 32'hAABBCCDD, 32'h11223344);
    $display("LWL off3 -> %h", bus.out_data);
    chk("lwl3_data", bus.out_data, 32'hAABBCCDD);
    pop_one();

    send(3'd6, 2'd3, 32'hAABBCCDD, 32'h11223344);
    $display("LWR off3 -> %h", bus.out_data);
    chk("lwr3_data", bus.out_data, 32'h112233AA);
    pop_one();

    send(3'd4, 2'd0, 32'hDEADBEEF, 32'h0);
    $display("LW  off0 -> %h", bus.out_data);
    chk("lw_data", bus.out_data, 32'hDEADBEEF);
    pop_one();

    send(3'd4, 2'd2, 32'hDEADBEEF, 32'h0);
    $display("LW  off2 -> %h err %0d cnt %0d", bus.out_data, bus.out_err, err_count);
    chk("lw_mis_data", bus.out_data, 32'h0);
    chk("lw_mis_err",  32'(bus.out_err), 32'd1);
    chk("lw_mis_cnt",  32'(err_count), 32'd2);
    pop_one();

    // Backpressure: two fill the buffer, third stalls until a slot frees.
    bus.mem_word = 32'h44332211;
    bus.load_type = 3'd1;
    bus.byte_offset = 2'd0;
    bus.in_valid = 1'b1;
    step();
    chk("bp_ready_after1", 32'(bus.in_ready), 32'd1);
    bus.byte_offset = 2'd1;
    step();
    chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head_a", bus.out_data, 32'h11);
    bus.byte_offset = 2'd2;
    step();
    chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_stable", bus.out_data, 32'h11);
    bus.out_ready = 1'b1;
    step();
    $display("BP pop1 -> head %h in_ready %0d", bus.out_data, bus.in_ready);
    chk("bp_head_b", bus.out_data, 32'h22);
    chk("bp_ready_free", 32'(bus.in_ready), 32'd1);
    step();
    $display("BP pop2 -> head %h valid %0d", bus.out_data, bus.out_valid);
    chk("bp_head_c", bus.out_data, 32'h33);
    chk("bp_valid_c", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Error counter saturation, then clear beating a same-cycle increment.
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_cnt", 32'(err_count), 32'd0);
    bus.load_type = 3'd7;
    bus.byte_offset = 2'd0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (256) step();
    $display("SAT 256 reserved -> cnt %0d err %0d", err_count, bus.out_err);
    chk("sat_cnt", 32'(err_count), 32'd255);
    chk("rsv_err", 32'(bus.out_err), 32'd1);
    chk("rsv_data", bus.out_data, 32'h0);
    err_clear = 1'b1;
    step();
    $display("SAT clear+err -> cnt %0d", err_count);
    chk("clr_prio_cnt", 32'(err_count), 32'd0);
    err_clear = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("sat_drained", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset with two entries buffered.
    send(3'd1, 2'd0, 32'h44332211, 32'h0);
    send(3'd1, 2'd1, 32'h44332211, 32'h0);
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    $display("RST mid-op -> valid %0d in_ready %0d", bus.out_valid, bus.in_ready);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_data",  bus.out_data, 32'h0);
    bus.load_type = 3'd1;
    bus.in_valid = 1'b1;
    step();
    chk("rst_no_accept", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    send(3'd0, 2'd0, 32'h000000FE, 32'h0);
    $display("POST-RST LB -> %h", bus.out_data);
    chk("post_rst_data", bus.out_data, 32'hFFFFFFFE);
    pop_one();
    chk("post_rst_nostale", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_load_extend.md
MEM_LOAD_EXTEND -- requirements
Module: mem_load_extend

Interface
REQ-001 Parameter WORD_W, default 32, datapath width in bits; SHALL be a multiple of 16 and at least 32.
REQ-002 Parameter FIFO_DEPTH, default 2, result-buffer entries; SHALL be a power of two and at least 2.
REQ-003 Parameter OFF_W, default $clog2(WORD_W/8), byte-offset width; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready at a clock edge.
REQ-008 load_type  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 reserved.
REQ-009 byte_offset  input  OFF_W  address low bits.
REQ-010 mem_word  input  WORD_W  aligned memory word; byte lane k = bits [8k+7:8k].
REQ-011 reg_old  input  WORD_W  current destination-register value, used by LWL/LWR.
REQ-012 out_valid  output  1  result present at FIFO head.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready at a clock edge.
REQ-014 out_data  output  WORD_W  extended/merged result.
REQ-015 out_err  output  1  head result came from a misaligned or reserved request.
REQ-016 err_clear  input  1  synchronous clear of err_count.
REQ-017 err_count  output  8  saturating count of accepted erroneous requests.

Function
REQ-018 Result SHALL be computed combinationally from accepted inputs and written into the FIFO on the acceptance edge; latency 1 cycle (out_valid high the cycle after acceptance if FIFO was empty).
REQ-019 in_ready SHALL be high iff FIFO not full; no same-cycle bypass when full, even if out_ready is high.
REQ-020 When FIFO is neither full nor empty, simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-021 FIFO SHALL be in-order; read/write pointers SHALL wrap modulo FIFO_DEPTH; a full/empty flag or extra pointer bit disambiguates.
REQ-022 out_data/out_err SHALL remain stable while out_valid && !out_ready.
REQ-023 LB/LBU: lane byte_offset, sign-/zero-extended to WORD_W.
REQ-024 LH/LHU: halfword at lanes {offset, offset+1}, sign-/zero-extended; misaligned if byte_offset[0]=1.
REQ-025 LW: full mem_word; misaligned if byte_offset != 0.
REQ-026 LWL, offset k: lanes 0..k of mem_word placed in result lanes (N-1-k)..(N-1), where N = WORD_W/8; lower lanes from reg_old; never misaligned.
REQ-027 LWR, offset k: lanes k..N-1 of mem_word placed in result lanes 0..(N-1-k); upper lanes from reg_old; never misaligned.
REQ-028 Misaligned or reserved (7) request: entry SHALL be written with out_data = 0 and out_err = 1; otherwise out_err = 0.
REQ-029 err_count SHALL increment by 1 on each accepted erroneous request, saturating at 255.
REQ-030 err_clear SHALL set err_count to 0 on the next edge and take priority over a same-cycle increment.
REQ-031 Requests with in_valid low, or not accepted, SHALL have no effect on state.

Reset
REQ-032 On reset low, immediately and asynchronously: FIFO emptied (pointers 0), out_valid=0, err_count=0, in_ready=1 (after the reset-driven empty state), out_data=0, out_err=0.
REQ-033 Reset mid-operation SHALL discard all buffered results; no partial entry is retained.
REQ-034 Release of reset SHALL take effect at the first rising edge with reset high; no acceptance occurs while reset is low.

Verification
REQ-035 LB, offset 2, mem_word 0x12A45678 -> out_data 0xFFFFFFA4, out_err 0, one cycle later; LBU -> 0x000000A4.
REQ-036 LH, offset 1, mem_word 0x12345678 -> out_data 0, out_err 1, err_count 1; LHU offset 2, mem 0x80010000 -> 0x00008001.
REQ-037 LWL offset 1, mem 0xAABBCCDD, reg_old 0x11223344 -> 0xCCDD3344; LWR offset 1 -> 0x11AABBCC.
REQ-038 out_ready held low, 3 back-to-back requests (FIFO_DEPTH 2) -> third stalls with in_ready 0; release out_ready -> results in order, third accepted the cycle after first pop.
REQ-039 256 reserved-type requests, then err_clear simultaneous with a further erroneous request -> err_count saturates at 255, then reads 0.
REQ-040 Reset asserted with 2 entries buffered -> out_valid 0 immediately; after release, first new request returns correct data with no stale entry.
